// File: rtl/robertsons_pkg.sv
// Shared types and defaults for the Robertson signed shift-add multiplier.
package robertsons_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_e;

   localparam int ROBERTSONS_N_DEFAULT = 4;

endpackage

// File: rtl/robertsons_multiplier_addsub.sv
// Combinational signed adder/subtractor for the N+1-bit Robertson accumulator.
module robertsons_addsub #(
   parameter int W = 5
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   output logic [W-1:0] sum_o
);

   assign sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/robertsons_multiplier.sv
// Sequential signed multiplier, Robertson's algorithm, one iteration per clock.
// Optional `ROBERTSONS_BUSY_EN adds a busy output that is high while iterating.
//
// state | meaning
// RUN   | iterating; count = iterations already completed
// DONE  | p holds the product, done held high until the next reset
module robertsons_multiplier
   import robertsons_pkg::*;
#(
   parameter int N = ROBERTSONS_N_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   q,
   input  logic [N-1:0]   m,
   output logic           done,
   output logic [2*N-1:0] p
`ifdef ROBERTSONS_BUSY_EN
   ,
   output logic           busy
`endif
);

   localparam int CW = $clog2(N) + 1;

   state_e           state_q, state_d;
   logic [N:0]       a_q, a_d;
   logic             f_q, f_d;
   logic [N-1:0]     q_q, q_d;
   logic [N-1:0]     m_q;
   logic [CW-1:0]    count_q, count_d;
   logic [2*N-1:0]   p_q, p_d;
   logic             done_q, done_d;

   logic             last;
   logic [N:0]       sum;
   logic [N:0]       acc;

   robertsons_addsub #(.W(N + 1)) u_addsub (
      .a_i   (a_q),
      .b_i   ({m_q[N-1], m_q}),
      .sub_i (last),
      .sum_o (sum)
   );

   // Operands load on the reset edge and on every clock while reset is held low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         a_q     <= '0;
         f_q     <= 1'b0;
         q_q     <= q;
         m_q     <= m;
         count_q <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         f_q     <= f_d;
         q_q     <= q_d;
         count_q <= count_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      f_d     = f_q;
      q_d     = q_q;
      count_d = count_q;
      p_d     = p_q;
      done_d  = done_q;
      last    = (count_q == CW'(N - 1));
      acc     = q_q[0] ? sum : a_q;

      if (state_q == RUN) begin
         if (last) begin
            a_d     = {acc[N], acc[N:1]};
            q_d     = {acc[0], q_q[N-1:1]};
            p_d     = {a_d[N-1:0], q_d};
            done_d  = 1'b1;
            state_d = DONE;
         end else begin
            // F remembers that a negative multiplicand has been added; it is the sign fill.
            f_d     = f_q | (m_q[N-1] & q_q[0]);
            a_d     = {f_d, acc[N:1]};
            q_d     = {acc[0], q_q[N-1:1]};
            count_d = count_q + CW'(1);
         end
      end
   end

   assign done = done_q;
   assign p    = p_q;

`ifdef ROBERTSONS_BUSY_EN
   assign busy = (state_q == RUN) && reset;
`endif

endmodule

// File: tb/tb_robertsons_multiplier.sv
// Directed, table-driven bench for robertsons_multiplier (N=4), with abort and hold sequences.
module tb_robertsons_multiplier;

   logic       clk;
   logic       reset;
   logic [3:0] q;
   logic [3:0] m;
   logic       done;
   logic [7:0] p;
`ifdef ROBERTSONS_BUSY_EN
   logic       busy;
`endif

   int n_vec = 0;
   int n_err = 0;

   robertsons_multiplier #(.N(4)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (q),
      .m     (m),
      .done  (done),
      .p     (p)
`ifdef ROBERTSONS_BUSY_EN
      ,
      .busy  (busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] q;
      logic [3:0] m;
      logic [7:0] p;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_busy(input string name, input logic exp);
`ifdef ROBERTSONS_BUSY_EN
      chk(name, {7'd0, busy}, {7'd0, exp});
`endif
   endtask

   // Apply operands with reset low for one full cycle, release at a falling edge.
   task automatic start(input logic [3:0] qv, input logic [3:0] mv);
      @(negedge clk);
      q     = qv;
      m     = mv;
      reset = 1'b0;
      #1;
      chk("reset_done", {7'd0, done}, 8'h00);
      chk("reset_p", p, 8'h00);
      chk_busy("reset_busy", 1'b0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{q: 4'hC, m: 4'h9, p: 8'h1C};  // -4 * -7 = 28
      vecs[1]  = '{q: 4'hC, m: 4'h3, p: 8'hF4};  // -4 *  3 = -12
      vecs[2]  = '{q: 4'h4, m: 4'h9, p: 8'hE4};  //  4 * -7 = -28
      vecs[3]  = '{q: 4'h4, m: 4'h3, p: 8'h0C};  //  4 *  3 = 12
      vecs[4]  = '{q: 4'h0, m: 4'h3, p: 8'h00};
      vecs[5]  = '{q: 4'h4, m: 4'h0, p: 8'h00};
      vecs[6]  = '{q: 4'h8, m: 4'h8, p: 8'h40};  // -8 * -8 = 64
      vecs[7]  = '{q: 4'h7, m: 4'h8, p: 8'hC8};  //  7 * -8 = -56
      vecs[8]  = '{q: 4'hF, m: 4'hF, p: 8'h01};  // -1 * -1 = 1
      vecs[9]  = '{q: 4'h7, m: 4'h7, p: 8'h31};  //  7 *  7 = 49
      vecs[10] = '{q: 4'h8, m: 4'h7, p: 8'hC8};  // -8 *  7 = -56
      vecs[11] = '{q: 4'h1, m: 4'h8, p: 8'hF8};  //  1 * -8 = -8

      reset = 1'b0;
      q     = '0;
      m     = '0;
      #12;
      chk("init_done", {7'd0, done}, 8'h00);
      chk("init_p", p, 8'h00);

      for (int i = 0; i < 12; i++) begin
         start(vecs[i].q, vecs[i].m);
         for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
               // Operand changes mid-run must be ignored.
               q = ~vecs[i].q;
               m = vecs[i].m + 4'd5;
            end
            if (e < 4) begin
               chk($sformatf("v%0d_run_done_e%0d", i, e), {7'd0, done}, 8'h00);
               chk($sformatf("v%0d_run_p_e%0d", i, e), p, 8'h00);
               chk_busy($sformatf("v%0d_busy_e%0d", i, e), 1'b1);
            end else begin
               chk($sformatf("v%0d_done", i), {7'd0, done}, 8'h01);
               chk($sformatf("v%0d_p", i), p, vecs[i].p);
               chk_busy($sformatf("v%0d_busy_end", i), 1'b0);
            end
         end
      end

      // Hold in DONE: clocks and operand changes have no effect.
      start(4'h7, 4'h9);  // 7 * -7 = -49 = 8'hCF
      repeat (4) @(posedge clk);
      #1;
      chk("hold_p0", p, 8'hCF);
      q = 4'h3;
      m = 4'h2;
      repeat (5) @(posedge clk);
      #1;
      chk("hold_p", p, 8'hCF);
      chk("hold_done", {7'd0, done}, 8'h01);
      chk_busy("hold_busy", 1'b0);

      // Abort after the 2nd edge, restart with 3 * 5.
      begin
         int busy_cycles;
         busy_cycles = 0;
         @(negedge clk);
         q     = 4'hC;
         m     = 4'h9;
         reset = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         chk("abort_pre_p", p, 8'h00);
         @(negedge clk);
         q     = 4'h3;
         m     = 4'h5;
         reset = 1'b0;
         #1;
         chk("abort_done", {7'd0, done}, 8'h00);
         chk("abort_p", p, 8'h00);
         @(negedge clk);
         reset = 1'b1;
         for (int e = 1; e <= 6; e++) begin
`ifdef ROBERTSONS_BUSY_EN
            if (busy) busy_cycles++;
`endif
            @(posedge clk);
            #1;
            if (e == 3) begin
               chk("abort_e3_done", {7'd0, done}, 8'h00);
               chk("abort_e3_p", p, 8'h00);
            end
            if (e == 4) begin
               chk("abort_e4_done", {7'd0, done}, 8'h01);
               chk("abort_e4_p", p, 8'h0F);
            end
         end
`ifdef ROBERTSONS_BUSY_EN
         chk("abort_busy_cycles", 8'(busy_cycles), 8'd4);
`endif
         chk("abort_final_p", p, 8'h0F);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
